// File: rtl/decode_pkg.sv
// Shared decode types for the RV64IM decode stage.
// Ops, branch kinds, memory sizes, opcodes and the decoded bundle.
package decode_pkg;

    typedef enum logic [3:0] {
        EX_NOP       = 4'd0,
        EX_ADD       = 4'd1,
        EX_SUB       = 4'd2,
        EX_OR        = 4'd3,
        EX_AND       = 4'd4,
        EX_XOR       = 4'd5,
        EX_SL        = 4'd6,
        EX_SR        = 4'd7,
        EX_MUL       = 4'd8,
        EX_DIV       = 4'd9,
        EX_REM       = 4'd10,
        EX_JUMP      = 4'd11,
        EX_LOAD_MEM  = 4'd12,
        EX_STORE_MEM = 4'd13
    } ex_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } branch_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef struct packed {
        logic [63:0] pc;
        ex_op_e      ex_opcode;
        branch_e     branch_type;
        logic [4:0]  r1_reg;
        logic [4:0]  r2_reg;
        logic [4:0]  dst_reg;
        logic [63:0] imm;
        logic        is_word_op;
        logic        imm_or_reg2;
        mem_size_e   mem_size;
        logic        mem_unsigned;
        logic        illegal;
    } decoded_t;

    function automatic logic [63:0] imm_i(input logic [31:0] i);
        return {{52{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] i);
        return {{52{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] imm_u(input logic [31:0] i);
        return {{32{i[31]}}, i[31:12], 12'b0};
    endfunction

    function automatic logic [63:0] imm_j(input logic [31:0] i);
        return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV64IM instruction decoder.
// Produces a fully populated decoded_t for every encoding.
module rv_decode_comb
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [63:0] pc,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       m_op;
    logic       bad;

    assign opcode = instr[6:0];
    assign f7     = instr[31:25];
    assign f3     = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign m_op   = (f7 == F7_MULD);

    always_comb begin
        dec    = '0;
        dec.pc = pc;
        bad    = 1'b0;
        unique case (1'b1)
            (opcode == OPC_OP_IMM): begin
                dec.r1_reg      = rs1;
                dec.dst_reg     = rd;
                dec.imm_or_reg2 = 1'b1;
                dec.imm         = imm_i(instr);
                unique case (f3)
                    3'b000: dec.ex_opcode = EX_ADD;
                    3'b100: dec.ex_opcode = EX_XOR;
                    3'b110: dec.ex_opcode = EX_OR;
                    3'b111: dec.ex_opcode = EX_AND;
                    3'b001: begin
                        dec.ex_opcode = EX_SL;
                        dec.imm = {58'b0, instr[25:20]};
                        bad = (instr[31:26] != 6'b0);
                    end
                    3'b101: begin
                        // imm[10] carries the arithmetic-shift flag
                        dec.ex_opcode = EX_SR;
                        dec.imm = {53'b0, instr[30], 4'b0, instr[25:20]};
                        bad = (instr[31:26] != 6'b000000)
                           && (instr[31:26] != 6'b010000);
                    end
                    default: bad = 1'b1;
                endcase
            end
            (opcode == OPC_IMM_32): begin
                dec.r1_reg      = rs1;
                dec.dst_reg     = rd;
                dec.imm_or_reg2 = 1'b1;
                dec.is_word_op  = 1'b1;
                dec.imm         = imm_i(instr);
                unique case (f3)
                    3'b000: dec.ex_opcode = EX_ADD;
                    3'b001: begin
                        dec.ex_opcode = EX_SL;
                        dec.imm = {59'b0, instr[24:20]};
                        bad = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.ex_opcode = EX_SR;
                        dec.imm = {53'b0, instr[30], 5'b0, instr[24:20]};
                        bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    default: bad = 1'b1;
                endcase
            end
            (opcode == OPC_OP): begin
                dec.r1_reg  = rs1;
                dec.r2_reg  = rs2;
                dec.dst_reg = rd;
                unique case (1'b1)
                    m_op: begin
                        bad = !ENABLE_M;
                        dec.ex_opcode = !f3[2] ? EX_MUL
                                      : (f3[1] ? EX_REM : EX_DIV);
                    end
                    (f7 == F7_BASE): begin
                        unique case (f3)
                            3'b000: dec.ex_opcode = EX_ADD;
                            3'b001: dec.ex_opcode = EX_SL;
                            3'b100: dec.ex_opcode = EX_XOR;
                            3'b101: dec.ex_opcode = EX_SR;
                            3'b110: dec.ex_opcode = EX_OR;
                            3'b111: dec.ex_opcode = EX_AND;
                            default: bad = 1'b1;
                        endcase
                    end
                    (f7 == F7_ALT): begin
                        unique case (f3)
                            3'b000: dec.ex_opcode = EX_SUB;
                            3'b101: begin
                                dec.ex_opcode = EX_SR;
                                dec.imm = 64'd1 << 10;
                            end
                            default: bad = 1'b1;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            (opcode == OPC_OP_32): begin
                dec.r1_reg     = rs1;
                dec.r2_reg     = rs2;
                dec.dst_reg    = rd;
                dec.is_word_op = 1'b1;
                unique case (1'b1)
                    m_op: begin
                        bad = !ENABLE_M || (f3 inside {3'b001, 3'b010, 3'b011});
                        dec.ex_opcode = !f3[2] ? EX_MUL
                                      : (f3[1] ? EX_REM : EX_DIV);
                    end
                    (f7 == F7_BASE): begin
                        unique case (f3)
                            3'b000: dec.ex_opcode = EX_ADD;
                            3'b001: dec.ex_opcode = EX_SL;
                            3'b101: dec.ex_opcode = EX_SR;
                            default: bad = 1'b1;
                        endcase
                    end
                    (f7 == F7_ALT): begin
                        unique case (f3)
                            3'b000: dec.ex_opcode = EX_SUB;
                            3'b101: begin
                                dec.ex_opcode = EX_SR;
                                dec.imm = 64'd1 << 10;
                            end
                            default: bad = 1'b1;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            (opcode == OPC_LUI), (opcode == OPC_AUIPC): begin
                // AUIPC reuses the otherwise idle branch_type as its PC-relative flag
                dec.ex_opcode   = EX_ADD;
                dec.dst_reg     = rd;
                dec.imm_or_reg2 = 1'b1;
                dec.imm         = imm_u(instr);
                dec.branch_type = (opcode == OPC_AUIPC) ? BR_JAL : BR_BEQ;
            end
            (opcode == OPC_JAL): begin
                dec.ex_opcode   = EX_JUMP;
                dec.branch_type = BR_JAL;
                dec.dst_reg     = rd;
                dec.imm_or_reg2 = 1'b1;
                dec.imm         = imm_j(instr);
            end
            (opcode == OPC_JALR): begin
                dec.ex_opcode   = EX_JUMP;
                dec.branch_type = BR_JALR;
                dec.r1_reg      = rs1;
                dec.dst_reg     = rd;
                dec.imm_or_reg2 = 1'b1;
                dec.imm         = imm_i(instr);
                bad = (f3 != 3'b000);
            end
            (opcode == OPC_BRANCH): begin
                dec.ex_opcode = EX_JUMP;
                dec.r1_reg    = rs1;
                dec.r2_reg    = rs2;
                dec.imm       = imm_b(instr);
                unique case (f3)
                    3'b000: dec.branch_type = BR_BEQ;
                    3'b001: dec.branch_type = BR_BNE;
                    3'b100: dec.branch_type = BR_BLT;
                    3'b101: dec.branch_type = BR_BGE;
                    3'b110: dec.branch_type = BR_BLTU;
                    3'b111: dec.branch_type = BR_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            (opcode == OPC_LOAD): begin
                dec.ex_opcode    = EX_LOAD_MEM;
                dec.r1_reg       = rs1;
                dec.dst_reg      = rd;
                dec.imm_or_reg2  = 1'b1;
                dec.imm          = imm_i(instr);
                dec.mem_size     = mem_size_e'(f3[1:0]);
                dec.mem_unsigned = f3[2];
                bad = (f3 == 3'b111);
            end
            (opcode == OPC_STORE): begin
                dec.ex_opcode   = EX_STORE_MEM;
                dec.r1_reg      = rs1;
                dec.r2_reg      = rs2;
                dec.imm_or_reg2 = 1'b1;
                dec.imm         = imm_s(instr);
                dec.mem_size    = mem_size_e'(f3[1:0]);
                bad = f3[2];
            end
            default: bad = 1'b1;
        endcase
        // The all-zero word also lands here and becomes a clean NOP bubble
        if (bad) begin
            dec         = '0;
            dec.pc      = pc;
            dec.illegal = (instr != 32'd0);
        end
    end

endmodule

// File: rtl/pipeline_decode_stage.sv
// Registered RV64IM decode stage between fetch and execute.
// Single-entry valid/ready register with flush and sync reset.
module pipeline_decode_stage
    import decode_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH/2-1:0]   instruction,
    input  logic [ADDR_WIDTH-1:0]     instruction_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     next_stage_pc,
    output logic [3:0]                ex_opcode,
    output logic [2:0]                branch_type,
    output logic [4:0]                r1_reg,
    output logic [4:0]                r2_reg,
    output logic [4:0]                dst_reg,
    output logic [DATA_WIDTH-1:0]     imm,
    output logic                      is_word_op,
    output logic                      imm_or_reg2,
    output logic [1:0]                mem_size,
    output logic                      mem_unsigned,
    output logic                      illegal
);

    decoded_t    dec;
    decoded_t    bundle_q;
    logic        valid_q;
    logic [31:0] instr_w;
    logic [63:0] pc_ext;

    assign instr_w = 32'(instruction);
    assign pc_ext  = 64'(instruction_pc);

    rv_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr (instr_w),
        .pc    (pc_ext),
        .dec   (dec)
    );

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign next_stage_pc = bundle_q.pc[ADDR_WIDTH-1:0];
    assign ex_opcode     = bundle_q.ex_opcode;
    assign branch_type   = bundle_q.branch_type;
    assign r1_reg        = bundle_q.r1_reg;
    assign r2_reg        = bundle_q.r2_reg;
    assign dst_reg       = bundle_q.dst_reg;
    assign imm           = bundle_q.imm[DATA_WIDTH-1:0];
    assign is_word_op    = bundle_q.is_word_op;
    assign imm_or_reg2   = bundle_q.imm_or_reg2;
    assign mem_size      = bundle_q.mem_size;
    assign mem_unsigned  = bundle_q.mem_unsigned;
    assign illegal       = bundle_q.illegal;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Directed self-checking bench for pipeline_decode_stage.
// Each scenario task drives vectors and compares against hand-decoded bundles.
module tb_pipeline_decode_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] next_stage_pc;
    logic [3:0]  ex_opcode;
    logic [2:0]  branch_type;
    logic [4:0]  r1_reg;
    logic [4:0]  r2_reg;
    logic [4:0]  dst_reg;
    logic [63:0] imm;
    logic        is_word_op;
    logic        imm_or_reg2;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    pipeline_decode_stage #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .ENABLE_M   (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .instruction_pc (instruction_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .next_stage_pc  (next_stage_pc),
        .ex_opcode      (ex_opcode),
        .branch_type    (branch_type),
        .r1_reg         (r1_reg),
        .r2_reg         (r2_reg),
        .dst_reg        (dst_reg),
        .imm            (imm),
        .is_word_op     (is_word_op),
        .imm_or_reg2    (imm_or_reg2),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, op, br, r1, r2, dst, imm, w, imm_sel, size, uns, ill}
    logic [92:0] obs;
    assign obs = {out_valid, ex_opcode, branch_type, r1_reg, r2_reg,
                  dst_reg, imm, is_word_op, imm_or_reg2, mem_size,
                  mem_unsigned, illegal};

    function automatic logic [92:0] ev(
        input logic v, input logic [3:0] op, input logic [2:0] br,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
        input logic [63:0] im, input logic w, input logic ir,
        input logic [1:0] ms, input logic mu, input logic il);
        return {v, op, br, a, b, d, im, w, ir, ms, mu, il};
    endfunction

    logic [92:0] e;

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1'b1;
        instruction = ins;
        instruction_pc = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; instruction = 32'hfe010113;
        instruction_pc = 64'h1000;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_bundle got %h exp %h", obs, e);
        end
        checks++;
        if (next_stage_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_pc got %h exp 0", next_stage_pc);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_alu;
        send(32'hfe010113, 64'h8000_0000_0000_1000);
        e = ev(1, 4'd1, 3'd0, 5'd2, 5'd0, 5'd2, -64'sd32, 0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL addi got %h exp %h", obs, e);
        end
        checks++;
        if (next_stage_pc !== 64'h8000_0000_0000_1000) begin
            errors++;
            $display("FAIL addi_pc got %h exp 8000000000001000", next_stage_pc);
        end
        send(32'h4035d513, 64'h1004);
        e = ev(1, 4'd7, 3'd0, 5'd11, 5'd0, 5'd10, 64'h403, 0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL srai got %h exp %h", obs, e);
        end
        send(32'h40c58533, 64'h1008);
        e = ev(1, 4'd2, 3'd0, 5'd11, 5'd12, 5'd10, 64'h0, 0, 0, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL sub got %h exp %h", obs, e);
        end
        send(32'h40c5d533, 64'h100c);
        e = ev(1, 4'd7, 3'd0, 5'd11, 5'd12, 5'd10, 64'h400, 0, 0, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL sra got %h exp %h", obs, e);
        end
        send(32'h02c5853b, 64'h1010);
        e = ev(1, 4'd8, 3'd0, 5'd11, 5'd12, 5'd10, 64'h0, 1, 0, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mulw got %h exp %h", obs, e);
        end
    endtask

    task automatic test_mem;
        send(32'h00113c23, 64'h2000);
        e = ev(1, 4'd13, 3'd0, 5'd2, 5'd1, 5'd0, 64'd24, 0, 1, 2'd3, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL sd got %h exp %h", obs, e);
        end
        send(32'hfff5c503, 64'h2004);
        e = ev(1, 4'd12, 3'd0, 5'd11, 5'd0, 5'd10, -64'sd1, 0, 1, 2'd0, 1, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL lbu got %h exp %h", obs, e);
        end
    endtask

    task automatic test_control;
        send(32'h00008067, 64'h3000);
        e = ev(1, 4'd11, 3'd7, 5'd1, 5'd0, 5'd0, 64'h0, 0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL ret got %h exp %h", obs, e);
        end
        send(32'hfe0a4ae3, 64'h3004);
        e = ev(1, 4'd11, 3'd2, 5'd20, 5'd0, 5'd0, -64'sd12, 0, 0, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL blt got %h exp %h", obs, e);
        end
        send(32'h008000ef, 64'h3008);
        e = ev(1, 4'd11, 3'd6, 5'd0, 5'd0, 5'd1, 64'd8, 0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL jal got %h exp %h", obs, e);
        end
    endtask

    task automatic test_upper;
        send(32'h80000537, 64'h4000);
        e = ev(1, 4'd1, 3'd0, 5'd0, 5'd0, 5'd10, 64'hffff_ffff_8000_0000,
               0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL lui got %h exp %h", obs, e);
        end
        send(32'h00001297, 64'h4004);
        e = ev(1, 4'd1, 3'd6, 5'd0, 5'd0, 5'd5, 64'h1000, 0, 1, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL auipc got %h exp %h", obs, e);
        end
    endtask

    task automatic test_illegal;
        e = ev(1, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'h0, 0, 0, 2'd0, 0, 1);
        send(32'h0000707f, 64'h5000);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL illegal_opc got %h exp %h", obs, e);
        end
        send(32'h0005f503, 64'h5004);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL illegal_load111 got %h exp %h", obs, e);
        end
        send(32'h00002063, 64'h5008);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL illegal_br010 got %h exp %h", obs, e);
        end
        send(32'h00000000, 64'h500c);
        e = ev(1, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'h0, 0, 0, 2'd0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL nop_zero got %h exp %h", obs, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [3];
        logic [4:0]  r1s [3];
        ins = '{32'hfe010113, 32'h00113c23, 32'h00008067};
        r1s = '{5'd2, 5'd2, 5'd1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instruction = ins[i];
            instruction_pc = 64'h6000 + 64'(i * 4);
            @(posedge clk);
            #1;
            checks++;
            if (!out_valid || r1_reg !== r1s[i]
                || next_stage_pc !== 64'h6000 + 64'(i * 4)) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b r1=%0d pc=%h exp v=1 r1=%0d",
                         i, out_valid, r1_reg, next_stage_pc, r1s[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [92:0] ea;
        logic [92:0] eb;
        ea = ev(1, 4'd1, 3'd0, 5'd2, 5'd0, 5'd2, -64'sd32, 0, 1, 2'd0, 0, 0);
        eb = ev(1, 4'd13, 3'd0, 5'd2, 5'd1, 5'd0, 64'd24, 0, 1, 2'd3, 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'hfe010113;
        instruction_pc = 64'h7000;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== ea || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_load got %h rdy=%b exp %h rdy=0",
                     obs, in_ready, ea);
        end
        @(negedge clk);
        instruction = 32'h00113c23;
        instruction_pc = 64'h7004;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== ea || in_ready !== 1'b0
                || next_stage_pc !== 64'h7000) begin
                errors++;
                $display("FAIL bp_hold_%0d got %h rdy=%b exp %h rdy=0",
                         i, obs, in_ready, ea);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb got %b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== eb || next_stage_pc !== 64'h7004) begin
            errors++;
            $display("FAIL bp_next got %h exp %h", obs, eb);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup got %b exp 0", out_valid);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruction = 32'h00008067;
        @(posedge clk);
        #1;
        @(negedge clk);
        instruction = 32'hfe0a4ae3;
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_stalled got v=%b rdy=%b exp v=0 rdy=1",
                     out_valid, in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped got %b exp 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        instruction = 32'hfe010113;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_xfer got %b exp 0", out_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_priority;
        send(32'hfe010113, 64'h9000);
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1;
        instruction = 32'h00113c23;
        @(posedge clk);
        #1;
        e = '0;
        checks++;
        if (obs !== e || next_stage_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_prio got %h pc=%h exp %h pc=0",
                     obs, next_stage_pc, e);
        end
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mem;
        test_control;
        test_upper;
        test_illegal;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_priority;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
